alu_16b: RTL and testbench

16-bit, 2-bit-opcode ALU for the stack processor datapath: OR, ADD, SUB and set-less-than on two signed 16-bit operands. The result, zero and overflow outputs are combinational. A clocked status register captures the flags of each cycle's operation for the control unit's conditional branches. The block sits between the operand stack outputs and the result/writeback mux.

---
 rtl/alu_16b.sv | 96 +++++++++
 tb/tb_alu_16b.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_16b.sv
// 16-bit ALU (OR/ADD/SUB/SLT) sharing one ripple-carry adder, plus a clocked status register.
// Define ALU16B_SLT_OVFL_FIX_EN to make SLT a true signed compare even when the subtraction overflows.
module alu_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  op,
  output logic [15:0] r,
  output logic        ovflw,
  output logic        zero,
  output logic        ovflw_q,
  output logic        zero_q,
  output logic        neg_q
);

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_SLT = 2'd3
  } op_t;

  logic        sub;
  logic [15:0] b_eff;
  logic [16:0] carry;
  logic [15:0] sum;
  logic        add_ov;
  logic        sub_ov;
  logic        lt;

  // Shared adder: SUB and SLT both reuse it as a + ~b + 1.
  always_comb begin
    sub      = (op != OP_ADD);
    b_eff    = b ^ {16{sub}};
    carry    = 17'd0;
    sum      = 16'd0;
    carry[0] = sub;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  always_comb begin
    add_ov = (a[15] == b[15]) && (sum[15] != a[15]);
    sub_ov = (a[15] != b[15]) && (sum[15] != a[15]);
`ifdef ALU16B_SLT_OVFL_FIX_EN
    lt = sum[15] ^ sub_ov;
`else
    lt = sum[15];
`endif
  end

  always_comb begin
    r     = 16'd0;
    ovflw = 1'b0;
    case (op_t'(op))
      OP_OR: begin
        r     = a | b;
        ovflw = 1'b0;
      end
      OP_ADD: begin
        r     = sum;
        ovflw = add_ov;
      end
      OP_SUB: begin
        r     = sum;
        ovflw = sub_ov;
      end
      OP_SLT: begin
        r     = {15'd0, lt};
        ovflw = sub_ov;
      end
      default: begin
        r     = 16'd0;
        ovflw = 1'b0;
      end
    endcase
    zero = ~|r;
  end

  // Flags of this cycle's operation, held for the control unit's branch decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovflw_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      ovflw_q <= ovflw;
      zero_q  <= zero;
      neg_q   <= r[15];
    end
  end

endmodule

// File: tb/tb_alu_16b.sv
// Directed self-checking bench for alu_16b: combinational ops, overflow/zero corners, SLT build
// variants and the status register with asynchronous reset.
module tb_alu_16b;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic [15:0] r;
  logic        ovflw;
  logic        zero;
  logic        ovflw_q;
  logic        zero_q;
  logic        neg_q;

  int errors;
  int checks;

  alu_16b dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .op      (op),
    .r       (r),
    .ovflw   (ovflw),
    .zero    (zero),
    .ovflw_q (ovflw_q),
    .zero_q  (zero_q),
    .neg_q   (neg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] op_in, input logic [15:0] a_in, input logic [15:0] b_in);
    op = op_in;
    a  = a_in;
    b  = b_in;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [15:0] slt_corner_exp;
  logic [15:0] slt_corner2_exp;
  logic [15:0] exp_r;

  initial begin
    errors = 0;
    checks = 0;
`ifdef ALU16B_SLT_OVFL_FIX_EN
    slt_corner_exp  = 16'h0001;
    slt_corner2_exp = 16'h0000;
`else
    slt_corner_exp  = 16'h0000;
    slt_corner2_exp = 16'h0001;
`endif

    rst = 1'b1;
    applyStimulus(2'd0, 16'h0000, 16'h0000);
    checkOutput("reset_ovflw_q", {15'd0, ovflw_q}, 16'd0);
    checkOutput("reset_zero_q", {15'd0, zero_q}, 16'd0);
    checkOutput("reset_neg_q", {15'd0, neg_q}, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_zero_q", {15'd0, zero_q}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'd1, 16'h7FFF, 16'h0001);
    checkOutput("add_ovf_r", r, 16'h8000);
    checkOutput("add_ovf_ovflw", {15'd0, ovflw}, 16'd1);
    checkOutput("add_ovf_zero", {15'd0, zero}, 16'd0);

    applyStimulus(2'd2, 16'h8000, 16'h0001);
    checkOutput("sub_ovf_r", r, 16'h7FFF);
    checkOutput("sub_ovf_ovflw", {15'd0, ovflw}, 16'd1);

    applyStimulus(2'd2, 16'h1234, 16'h1234);
    checkOutput("sub_eq_r", r, 16'h0000);
    checkOutput("sub_eq_zero", {15'd0, zero}, 16'd1);
    checkOutput("sub_eq_ovflw", {15'd0, ovflw}, 16'd0);

    applyStimulus(2'd0, 16'h0000, 16'h0000);
    checkOutput("or_zero_r", r, 16'h0000);
    checkOutput("or_zero_zero", {15'd0, zero}, 16'd1);

    applyStimulus(2'd0, 16'h00F0, 16'h0F0F);
    checkOutput("or_r", r, 16'h0FFF);
    checkOutput("or_zero", {15'd0, zero}, 16'd0);

    applyStimulus(2'd1, 16'hFFFF, 16'h0001);
    checkOutput("add_wrap_r", r, 16'h0000);
    checkOutput("add_wrap_ovflw", {15'd0, ovflw}, 16'd0);
    checkOutput("add_wrap_zero", {15'd0, zero}, 16'd1);

    applyStimulus(2'd2, 16'h0000, 16'h8000);
    checkOutput("sub_min_r", r, 16'h8000);
    checkOutput("sub_min_ovflw", {15'd0, ovflw}, 16'd1);

    applyStimulus(2'd3, 16'd5, 16'd3);
    checkOutput("slt_gt_r", r, 16'h0000);
    checkOutput("slt_gt_zero", {15'd0, zero}, 16'd1);
    checkOutput("slt_gt_ovflw", {15'd0, ovflw}, 16'd0);

    applyStimulus(2'd3, 16'd3, 16'd5);
    checkOutput("slt_lt_r", r, 16'h0001);
    checkOutput("slt_lt_zero", {15'd0, zero}, 16'd0);

    applyStimulus(2'd3, 16'hFFFE, 16'h0001);
    checkOutput("slt_neg_r", r, 16'h0001);

    applyStimulus(2'd3, 16'h8000, 16'h0001);
    checkOutput("slt_corner_ovflw", {15'd0, ovflw}, 16'd1);
    checkOutput("slt_corner_r", r, slt_corner_exp);

    applyStimulus(2'd3, 16'h7FFF, 16'hFFFF);
    checkOutput("slt_corner2_ovflw", {15'd0, ovflw}, 16'd1);
    checkOutput("slt_corner2_r", r, slt_corner2_exp);

    // Strided sweep over -256..255; no overflow is possible in this range.
    for (int ia = -256; ia <= 255; ia += 17) begin
      for (int ib = -256; ib <= 255; ib += 13) begin
        for (int k = 0; k < 4; k++) begin
          case (k)
            0:       exp_r = 16'(ia | ib);
            1:       exp_r = 16'(ia + ib);
            2:       exp_r = 16'(ia - ib);
            default: exp_r = (ia < ib) ? 16'd1 : 16'd0;
          endcase
          applyStimulus(2'(k), 16'(ia), 16'(ib));
          checkOutput("sweep_r", r, exp_r);
          checkOutput("sweep_zero", {15'd0, zero}, {15'd0, exp_r == 16'd0});
          checkOutput("sweep_ovflw", {15'd0, ovflw}, 16'd0);
        end
      end
    end

    applyStimulus(2'd1, 16'h7FFF, 16'h0001);
    @(posedge clk);
    #1;
    checkOutput("status_ovflw_q", {15'd0, ovflw_q}, 16'd1);
    checkOutput("status_neg_q", {15'd0, neg_q}, 16'd1);
    checkOutput("status_zero_q", {15'd0, zero_q}, 16'd0);

    rst = 1'b1;
    #1;
    checkOutput("async_rst_ovflw_q", {15'd0, ovflw_q}, 16'd0);
    checkOutput("async_rst_neg_q", {15'd0, neg_q}, 16'd0);
    checkOutput("async_rst_zero_q", {15'd0, zero_q}, 16'd0);
    checkOutput("rst_comb_r", r, 16'h8000);
    checkOutput("rst_comb_ovflw", {15'd0, ovflw}, 16'd1);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'd2, 16'd7, 16'd7);
    @(posedge clk);
    #1;
    checkOutput("post_rst_zero_q", {15'd0, zero_q}, 16'd1);
    checkOutput("post_rst_ovflw_q", {15'd0, ovflw_q}, 16'd0);
    checkOutput("post_rst_neg_q", {15'd0, neg_q}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
